arp_responder_multi: RTL
========================

ARP_RESPONDER_MULTI -- requirements
Module: arp_responder_multi

Interface
REQ-001 Parameter N_IP, default 2: number of local IPv4 addresses answered (1..8).
REQ-002 clock  in  1  single clock for receive and transmit.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 rx_enable  in  1  high while ARP payload bytes are presented, one byte per clock; first byte is hardware-type MSB.
REQ-005 rx_data  in  8  received payload byte.
REQ-006 local_mac  in  48  our MAC address.
REQ-007 local_ip  in  32*N_IP  local addresses; entry i is bits [32*i+31 : 32*i].
REQ-008 ip_valid  in  N_IP  entry i is answered only when bit i is high.
REQ-009 tx_enable  in  1  one-cycle grant from the transmit arbiter.
REQ-010 tx_data  out  8  reply byte stream.
REQ-011 destination_mac  out  48  Ethernet destination for the pending frame.
REQ-012 tx_request  out  1  frame pending, awaiting grant.
REQ-013 tx_active  out  1  block owns the transmitter.
REQ-014 match_index  out  3  index of the entry being answered.

Function
REQ-015 States: IDLE, RX, DROP, TXREQ, TX.
REQ-016 IDLE->RX on rx_enable high; that byte is offset 0, and the offset counter increments once per clock while rx_enable is high.
REQ-017 In RX, offsets 0-7 must equal 00 01 08 00 06 04 00 01; any mismatch -> DROP.
REQ-018 Offsets 8-13 are captured as sender MAC (SHA); offsets 14-17 are captured as sender IP (SPA).
REQ-019 Offsets 24-27 (TPA) are compared in parallel against every valid entry; an entry that mismatches any byte is eliminated.
REQ-020 At offset 27: if any entry survives, go to TXREQ, set match_index to the lowest surviving index and destination_mac to SHA; if none survives, go to DROP.
REQ-021 rx_enable low in RX before offset 27 -> IDLE with no reply.
REQ-022 DROP -> IDLE when rx_enable is low.
REQ-023 Bytes after offset 27 (padding) and any rx activity during TXREQ or TX are ignored; the block does not queue a second reply.
REQ-024 tx_request is high exactly while in TXREQ; tx_enable sampled high in TXREQ -> TX.
REQ-025 Reply is 30 bytes, MSB first: 08 06 00 01 08 00 06 04 00 02, local_mac, local_ip[match_index], SHA, SPA.
REQ-026 Byte 0 appears on tx_data in the tx_enable cycle; byte k appears k cycles later.
REQ-027 tx_active = tx_enable OR (state==TX), and drops the cycle after byte 29.
REQ-028 TX -> IDLE after byte 29; tx_data is 00 whenever tx_active is low.
REQ-029 ip_valid and local_ip are sampled at TPA compare time; later changes do not alter a pending reply except through the match_index entry value.

Reset
REQ-030 Reset asserted at any time (including mid-RX or mid-TX) forces IDLE immediately, with tx_request=0, tx_active=0, tx_data=00, destination_mac=0, match_index=0, and clears all captured fields.

Configuration
REQ-031 Macro ARP_RESPONDER_GRATUITOUS_EN adds input announce (1 bit); when absent, the port and logic do not exist and behaviour is REQ-001..030.
REQ-032 With the macro defined, an announce pulse latches a pending mask equal to ip_valid.
REQ-033 While in IDLE with the mask non-zero, the block sends a gratuitous request for the lowest set bit: oper 0001, SPA=TPA=that IP, THA=0, destination_mac=FF:FF:FF:FF:FF:FF, and clears that bit on completion.
REQ-034 A received request that matches takes priority over pending announcements; announce during an announcement re-latches the mask.

Verification
REQ-035 Request with TPA=192.168.1.20 = entry 1 (entry 0 = .10, both valid) -> tx_request, match_index=1, reply bytes 10-29 = local_mac, C0A80114, SHA, SPA.
REQ-036 Same request with ip_valid=01 -> DROP, no tx_request, IDLE after rx_enable falls.
REQ-037 Opcode byte 7 = 02 -> DROP; rx_enable falling at offset 20 -> IDLE, no reply.
REQ-038 tx_enable held off 50 cycles -> tx_request stays high, and the reply is unchanged once granted; tx_active spans exactly 30 cycles.
REQ-039 Reset at reply byte 12 -> tx_active=0 the same cycle; the next valid request is answered normally.
REQ-040 With ARP_RESPONDER_GRATUITOUS_EN, announce with ip_valid=11 -> two broadcast frames, .10 then .20, each with SPA=TPA.

Source files
------------

// File: rtl/arp_responder_multi_if.sv
// rtl/arp_responder_multi_if.sv - receive/transmit byte-stream bundle for arp_responder_multi
//
// Purpose: groups the ARP receive stream, the transmit arbiter handshake and
// the pending-frame status into one interface.
// Modports:
//   master - the surrounding MAC/arbiter: drives rx_enable, rx_data, tx_enable;
//            observes tx_data, destination_mac, tx_request, tx_active, match_index
//   slave  - the responder: the mirror image of master

interface arp_responder_multi_if;
  logic        rx_enable;
  logic [7:0]  rx_data;
  logic        tx_enable;
  logic [7:0]  tx_data;
  logic [47:0] destination_mac;
  logic        tx_request;
  logic        tx_active;
  logic [2:0]  match_index;

  modport master (
    output rx_enable, rx_data, tx_enable,
    input  tx_data, destination_mac, tx_request, tx_active, match_index
  );

  modport slave (
    input  rx_enable, rx_data, tx_enable,
    output tx_data, destination_mac, tx_request, tx_active, match_index
  );
endinterface

// File: rtl/arp_responder_multi.sv
// rtl/arp_responder_multi.sv - ARP responder answering requests for up to 8 local IPv4 addresses
//
// Purpose: parses an incoming ARP payload byte stream, answers requests whose
// target IP matches any valid local entry, and streams a 30-byte reply
// (ethertype + ARP payload) once the transmit arbiter grants.
// Optional feature: define ARP_RESPONDER_GRATUITOUS_EN to add the announce
// input, which queues one gratuitous ARP request per valid local address.
// Ports:
//   clock, reset     - single clock, asynchronous active-high reset
//   bus (slave)      - rx_enable/rx_data in, tx_enable grant in,
//                      tx_data/destination_mac/tx_request/tx_active/match_index out
//   local_mac        - our MAC address
//   local_ip         - N_IP packed IPv4 addresses, entry i at [32*i+31:32*i]
//   ip_valid         - per-entry enable
//   announce         - (ARP_RESPONDER_GRATUITOUS_EN only) latch ip_valid as pending announcements

module arp_responder_multi #(
  parameter int N_IP = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  arp_responder_multi_if.slave  bus,
  input  logic [47:0]           local_mac,
  input  logic [32*N_IP-1:0]    local_ip,
  input  logic [N_IP-1:0]       ip_valid
`ifdef ARP_RESPONDER_GRATUITOUS_EN
  ,
  input  logic                  announce
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RX    = 3'd1,
    S_DROP  = 3'd2,
    S_TXREQ = 3'd3,
    S_TX    = 3'd4
  } state_t;

  state_t state, state_next;

  logic [4:0]      rx_offset;
  logic [47:0]     sha;
  logic [31:0]     spa;
  logic [N_IP-1:0] survive;
  logic [N_IP-1:0] survive_next;
  logic [N_IP-1:0] tpa_hit;
  logic            rx_armed;
  logic            rx_start;
  logic            hdr_ok;
  logic [4:0]      tx_count;
  logic [2:0]      match_index_r;
  logic [47:0]     dest_mac_r;
  logic [N_IP-1:0] grat_pending;
  logic            grat_go;
  logic            is_grat;
  logic [31:0]     my_ip;
  logic [239:0]    frame;
  logic [4:0]      tx_idx;
  logic            tx_active_c;
  logic [7:0]      tx_data_c;
  int              tpa_shift;
  int              tx_shift;

  // Fixed ARP-over-Ethernet request header: htype 0001, ptype 0800, hlen 6, plen 4, oper 0001.
  function automatic logic [7:0] hdr_byte(input logic [2:0] off);
    case (off)
      3'd0:    hdr_byte = 8'h00;
      3'd1:    hdr_byte = 8'h01;
      3'd2:    hdr_byte = 8'h08;
      3'd3:    hdr_byte = 8'h00;
      3'd4:    hdr_byte = 8'h06;
      3'd5:    hdr_byte = 8'h04;
      3'd6:    hdr_byte = 8'h00;
      default: hdr_byte = 8'h01;
    endcase
  endfunction

  function automatic logic [2:0] lowest_index(input logic [N_IP-1:0] m);
    lowest_index = 3'd0;
    for (int i = N_IP - 1; i >= 0; i--) begin
      if (m[i]) lowest_index = 3'(i);
    end
  endfunction

  // A new frame may only start after rx_enable has been seen low, so trailing
  // padding of an already-handled frame is never parsed as a fresh header.
  assign rx_start = bus.rx_enable && rx_armed;
  assign hdr_ok   = (bus.rx_data == hdr_byte(rx_offset[2:0]));
  assign grat_go  = |grat_pending;

  // TPA bytes arrive MSB first at offsets 24..27; compare each against the
  // matching byte of every entry at once.
  always_comb begin
    tpa_shift = 24 - 8 * int'(rx_offset[1:0]);
    for (int i = 0; i < N_IP; i++) begin
      tpa_hit[i] = (bus.rx_data == local_ip[32*i + tpa_shift +: 8]);
    end
    survive_next = (rx_offset == 5'd24) ? (ip_valid & tpa_hit) : (survive & tpa_hit);
  end

  // FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM: next state; received requests win over pending announcements
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (rx_start)     state_next = (bus.rx_data == 8'h00) ? S_RX : S_DROP;
        else if (grat_go) state_next = S_TXREQ;
      end
      S_RX: begin
        if (!bus.rx_enable)                  state_next = S_IDLE;
        else if (rx_offset < 5'd8 && !hdr_ok) state_next = S_DROP;
        else if (rx_offset == 5'd27)         state_next = (|survive_next) ? S_TXREQ : S_DROP;
      end
      S_DROP:  if (!bus.rx_enable) state_next = S_IDLE;
      S_TXREQ: if (bus.tx_enable)  state_next = S_TX;
      S_TX:    if (tx_count == 5'd29) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs. Byte 0 is shown combinationally in the grant cycle.
  always_comb begin
    my_ip = 32'h0;
    for (int i = 0; i < N_IP; i++) begin
      if (match_index_r == 3'(i)) my_ip = local_ip[32*i +: 32];
    end
    frame = {16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 8'h00,
             (is_grat ? 8'h01 : 8'h02),
             local_mac, my_ip,
             (is_grat ? 48'h0 : sha),
             (is_grat ? my_ip : spa)};
    tx_active_c = (state == S_TXREQ && bus.tx_enable) || (state == S_TX);
    tx_idx      = (state == S_TX) ? tx_count : 5'd0;
    tx_shift    = 8 * (29 - int'(tx_idx));
    tx_data_c   = tx_active_c ? frame[tx_shift +: 8] : 8'h00;
  end

  assign bus.tx_request      = (state == S_TXREQ);
  assign bus.tx_active       = tx_active_c;
  assign bus.tx_data         = tx_data_c;
  assign bus.destination_mac = dest_mac_r;
  assign bus.match_index     = match_index_r;

  // Receive capture, match bookkeeping and transmit byte counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_offset     <= 5'd0;
      sha           <= 48'h0;
      spa           <= 32'h0;
      survive       <= '0;
      rx_armed      <= 1'b1;
      tx_count      <= 5'd0;
      match_index_r <= 3'd0;
      dest_mac_r    <= 48'h0;
    end else begin
      if (!bus.rx_enable) rx_armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (rx_start) begin
            rx_armed  <= 1'b0;
            rx_offset <= 5'd1;
            survive   <= '0;
          end else if (grat_go) begin
            match_index_r <= lowest_index(grat_pending);
            dest_mac_r    <= 48'hFFFF_FFFF_FFFF;
          end
        end
        S_RX: begin
          if (bus.rx_enable) begin
            rx_offset <= rx_offset + 5'd1;
            if (rx_offset >= 5'd8 && rx_offset <= 5'd13)  sha <= {sha[39:0], bus.rx_data};
            if (rx_offset >= 5'd14 && rx_offset <= 5'd17) spa <= {spa[23:0], bus.rx_data};
            if (rx_offset >= 5'd24) survive <= survive_next;
            if (rx_offset == 5'd27 && (|survive_next)) begin
              match_index_r <= lowest_index(survive_next);
              dest_mac_r    <= sha;
            end
          end
        end
        S_TXREQ: if (bus.tx_enable) tx_count <= 5'd1;
        S_TX:    tx_count <= tx_count + 5'd1;
        default: ;
      endcase
    end
  end

`ifdef ARP_RESPONDER_GRATUITOUS_EN
  // Pending announcement mask; a new announce pulse simply re-latches it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grat_pending <= '0;
      is_grat      <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        if (rx_start)     is_grat <= 1'b0;
        else if (grat_go) is_grat <= 1'b1;
      end
      if (announce) begin
        grat_pending <= ip_valid;
      end else if (state == S_TX && tx_count == 5'd29 && is_grat) begin
        for (int i = 0; i < N_IP; i++) begin
          if (match_index_r == 3'(i)) grat_pending[i] <= 1'b0;
        end
      end
    end
  end
`else
  assign grat_pending = '0;
  assign is_grat      = 1'b0;
`endif

endmodule
